// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator motion controller, its scheduler and bench.
// Floor encoding, motion state enum and small arithmetic helpers.
package elevator_pkg;

    localparam int unsigned FLOOR_W = 4;

    localparam logic [FLOOR_W-1:0] FLOOR_NONE = 4'd0;
    localparam logic [FLOOR_W-1:0] FLOOR_MIN  = 4'd1;
    localparam logic [FLOOR_W-1:0] FLOOR_MAX  = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StMoving,
        StDoorOpen,
        StPop
    } motion_state_t;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One floor step in the given direction, saturating at the building limits.
    function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] floor,
                                                     input logic               up);
        logic [FLOOR_W-1:0] nxt;
        nxt = floor;
        if (up) begin
            if (floor != FLOOR_MAX) begin
                nxt = floor + 1'b1;
            end
        end else begin
            if (floor != FLOOR_MIN) begin
                nxt = floor - 1'b1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Down-counting interval timer: load starts a LOAD-cycle interval, done marks its last cycle.
// Used for both the per-floor travel time and the door-open time.
module elev_timer
    import elevator_pkg::*;
#(
    parameter int unsigned LOAD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CntW = cnt_width(LOAD);
    localparam logic [CntW-1:0] LoadM1 = CntW'(LOAD - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LoadM1;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/elevator_motion_ctrl.sv
// Car motion FSM: drives toward the queue head one floor at a time, opens the door, pops.
// Optional door-hold input is enabled by defining ELEV_DOOR_HOLD_EN.
module elevator_motion_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = 8,
    parameter int unsigned DOOR_CYCLES   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] head_floor,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic               door_hold,
`endif
    output logic               shift,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               dir_up,
    output logic               dir_down,
    output logic               door_open,
    output logic               arrived
);

    motion_state_t      state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_up_q, dir_up_d;
    logic               dir_down_q, dir_down_d;
    logic               door_open_q, door_open_d;
    logic               arrived_q, arrived_d;
    logic               shift_q, shift_d;

    logic               trv_load, trv_en, trv_done;
    logic               door_load, door_en, door_done;
    logic               hold;
    logic [FLOOR_W-1:0] next_floor;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    elev_timer #(
        .LOAD (TRAVEL_CYCLES)
    ) u_travel_timer (
        .clk   (clk),
        .reset (reset),
        .load  (trv_load),
        .en    (trv_en),
        .done  (trv_done)
    );

    elev_timer #(
        .LOAD (DOOR_CYCLES)
    ) u_door_timer (
        .clk   (clk),
        .reset (reset),
        .load  (door_load),
        .en    (door_en),
        .done  (door_done)
    );

    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_up_d    = dir_up_q;
        dir_down_d  = dir_down_q;
        door_open_d = door_open_q;
        arrived_d   = 1'b0;
        shift_d     = 1'b0;
        trv_load    = 1'b0;
        trv_en      = 1'b0;
        door_load   = 1'b0;
        door_en     = 1'b0;
        next_floor  = step_floor(floor_q, dir_up_q);

        unique case (state_q)
            StIdle: begin
                if (head_floor == FLOOR_NONE) begin
                    state_d = StIdle;
                end else if (head_floor == floor_q) begin
                    state_d     = StDoorOpen;
                    door_load   = 1'b1;
                    door_open_d = 1'b1;
                    arrived_d   = 1'b1;
                end else begin
                    state_d    = StMoving;
                    trv_load   = 1'b1;
                    dir_up_d   = (head_floor > floor_q);
                    dir_down_d = !(head_floor > floor_q);
                end
            end

            StMoving: begin
                if (!trv_done) begin
                    trv_en = 1'b1;
                end else begin
                    // Floor boundary: the head is judged against the floor we step onto.
                    floor_d = next_floor;
                    if (head_floor == next_floor) begin
                        state_d     = StDoorOpen;
                        door_load   = 1'b1;
                        door_open_d = 1'b1;
                        arrived_d   = 1'b1;
                        dir_up_d    = 1'b0;
                        dir_down_d  = 1'b0;
                    end else if (head_floor == FLOOR_NONE) begin
                        state_d    = StIdle;
                        dir_up_d   = 1'b0;
                        dir_down_d = 1'b0;
                    end else begin
                        state_d    = StMoving;
                        trv_load   = 1'b1;
                        dir_up_d   = (head_floor > next_floor);
                        dir_down_d = !(head_floor > next_floor);
                    end
                end
            end

            StDoorOpen: begin
                if (hold) begin
                    door_load = 1'b1;
                end else if (!door_done) begin
                    door_en = 1'b1;
                end else begin
                    state_d     = StPop;
                    door_open_d = 1'b0;
                    shift_d     = 1'b1;
                end
            end

            StPop: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            floor_q     <= FLOOR_MIN;
            dir_up_q    <= 1'b0;
            dir_down_q  <= 1'b0;
            door_open_q <= 1'b0;
            arrived_q   <= 1'b0;
            shift_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            dir_up_q    <= dir_up_d;
            dir_down_q  <= dir_down_d;
            door_open_q <= door_open_d;
            arrived_q   <= arrived_d;
            shift_q     <= shift_d;
        end
    end

    assign shift         = shift_q;
    assign current_floor = floor_q;
    assign dir_up        = dir_up_q;
    assign dir_down      = dir_down_q;
    assign door_open     = door_open_q;
    assign arrived       = arrived_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Scoreboard bench for elevator_motion_ctrl: stimulus queues expected floor steps, arrivals
// and pops with their cycle numbers; a monitor compares them. ELEV_DOOR_HOLD_EN adds hold test.
module tb_elevator_motion_ctrl;
    import elevator_pkg::*;

    localparam int T = 4;
    localparam int D = 6;

    localparam int EvStep   = 0;
    localparam int EvArrive = 1;
    localparam int EvShift  = 2;

    typedef struct {
        int kind;
        int floor;
        int cyc;
        int a;
        int b;
    } ev_t;

    logic               clk;
    logic               reset;
    logic [FLOOR_W-1:0] head_floor;
    logic               shift;
    logic [FLOOR_W-1:0] current_floor;
    logic               dir_up;
    logic               dir_down;
    logic               door_open;
    logic               arrived;
`ifdef ELEV_DOOR_HOLD_EN
    logic               door_hold;
`endif

    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    int  excl_viol = 0;
    int  model_floor = 1;
    ev_t exp_q[$];

    elevator_motion_ctrl #(
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .head_floor    (head_floor),
`ifdef ELEV_DOOR_HOLD_EN
        .door_hold     (door_hold),
`endif
        .shift         (shift),
        .current_floor (current_floor),
        .dir_up        (dir_up),
        .dir_down      (dir_down),
        .door_open     (door_open),
        .arrived       (arrived)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            EvStep:   return "step";
            EvArrive: return "arrive";
            default:  return "shift";
        endcase
    endfunction

    task automatic push(input int kind, input int fl, input int c, input int a, input int b);
        ev_t e;
        e.kind  = kind;
        e.floor = fl;
        e.cyc   = c;
        e.a     = a;
        e.b     = b;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic observe(input int kind, input int fl, input int a, input int b);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_%s: got floor=%0d cycle=%0d, nothing expected",
                     kname(kind), fl, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.floor != fl || e.cyc != cyc || e.a != a || e.b != b) begin
                n_err++;
                $display("FAIL %s: got %s floor=%0d cycle=%0d runs=%0d/%0d, expected %s floor=%0d cycle=%0d runs=%0d/%0d",
                         kname(e.kind), kname(kind), fl, cyc, a, b,
                         kname(e.kind), e.floor, e.cyc, e.a, e.b);
            end
        end
    endtask

    // Monitor: run lengths of travel and door cycles are reported with each event.
    initial begin
        int up_run;
        int dn_run;
        int door_run;
        int prev_floor;
        up_run = 0;
        dn_run = 0;
        door_run = 0;
        prev_floor = 1;
        forever begin
            @(negedge clk);
            if (reset) begin
                up_run = 0;
                dn_run = 0;
                door_run = 0;
                prev_floor = int'(current_floor);
            end else begin
                if (dir_up && dir_down) excl_viol++;
                if ((dir_up || dir_down) && door_open) excl_viol++;
                if (int'(current_floor) != prev_floor) begin
                    observe(EvStep, int'(current_floor), 0, 0);
                    prev_floor = int'(current_floor);
                end
                if (arrived) begin
                    observe(EvArrive, int'(current_floor), up_run, dn_run);
                    up_run = 0;
                    dn_run = 0;
                    door_run = 0;
                end
                if (door_open) door_run++;
                if (shift) begin
                    observe(EvShift, int'(current_floor), door_run, 0);
                    door_run = 0;
                end
                if (dir_up) up_run++;
                if (dir_down) dn_run++;
                if (!dir_up && !dir_down && !door_open && !arrived && !shift) begin
                    up_run = 0;
                    dn_run = 0;
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Straight trip with a steady head; returns at the edge that pops the request.
    task automatic trip(input int s, input int t);
        int k;
        int n;
        int arr;
        k = cyc;
        head_floor = 4'(t);
        n = (t > s) ? t - s : s - t;
        for (int i = 1; i <= n; i++) begin
            push(EvStep, (t > s) ? s + i : s - i, k + 1 + i * T, 0, 0);
        end
        arr = k + 1 + n * T;
        push(EvArrive, t, arr, (t > s) ? n * T : 0, (t < s) ? n * T : 0);
        push(EvShift, t, arr + D, D, 0);
        model_floor = t;
        wait_cyc(arr + D + 1);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        head_floor = 4'd0;
`ifdef ELEV_DOOR_HOLD_EN
        door_hold = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_floor", int'(current_floor), 1);
        check("reset_outputs", int'({shift, dir_up, dir_down, door_open, arrived}), 0);

        wait_cyc(cyc + 50);
        check("idle_floor", int'(current_floor), 1);
        check("idle_outputs", int'({shift, dir_up, dir_down, door_open, arrived}), 0);

        // Same floor, then drain: no further pop with an empty queue.
        trip(1, 1);
        head_floor = 4'd0;
        wait_cyc(cyc + 20);
        check("drain_floor", int'(current_floor), 1);

        // Upward trip, then a back-to-back downward request presented at the pop edge.
        trip(1, 3);
        trip(3, 1);
        head_floor = 4'd0;
        wait_cyc(cyc + 5);

        // Retarget 5 -> 2 before the first floor boundary.
        k = cyc;
        head_floor = 4'd5;
        push(EvStep, 2, k + 5, 0, 0);
        push(EvArrive, 2, k + 5, 4, 0);
        push(EvShift, 2, k + 11, D, 0);
        wait_cyc(k + 2);
        head_floor = 4'd2;
        wait_cyc(k + 12);
        head_floor = 4'd0;
        model_floor = 2;
        wait_cyc(cyc + 5);

        // Reversal: head flips below the car, direction turns at the boundary.
        k = cyc;
        head_floor = 4'd6;
        push(EvStep, 3, k + 5, 0, 0);
        push(EvStep, 2, k + 9, 0, 0);
        push(EvStep, 1, k + 13, 0, 0);
        push(EvArrive, 1, k + 13, 4, 8);
        push(EvShift, 1, k + 19, D, 0);
        wait_cyc(k + 2);
        head_floor = 4'd1;
        wait_cyc(k + 20);
        head_floor = 4'd0;
        model_floor = 1;
        wait_cyc(cyc + 5);

        // Queue empties mid-trip: stop at the next boundary without a door cycle.
        k = cyc;
        head_floor = 4'd3;
        push(EvStep, 2, k + 5, 0, 0);
        wait_cyc(k + 2);
        head_floor = 4'd0;
        wait_cyc(k + 10);
        check("empty_stop_floor", int'(current_floor), 2);
        check("empty_stop_dirs", int'({dir_up, dir_down, door_open}), 0);
        model_floor = 2;

        // Reset while travelling toward 9; the request is still at the head afterwards.
        k = cyc;
        head_floor = 4'd9;
        push(EvStep, 3, k + 5, 0, 0);
        push(EvStep, 4, k + 9, 0, 0);
        wait_cyc(k + 11);
        reset = 1'b1;
        #1;
        check("midreset_floor", int'(current_floor), 1);
        check("midreset_outputs", int'({shift, dir_up, dir_down, door_open, arrived}), 0);
        wait_cyc(k + 13);
        reset = 1'b0;
        trip(1, 9);
        trip(9, 15);
        head_floor = 4'd0;
        wait_cyc(cyc + 5);

`ifdef ELEV_DOOR_HOLD_EN
        // Hold for 10 cycles mid-door; the door closes DOOR_CYCLES after release.
        k = cyc;
        head_floor = 4'd15;
        push(EvArrive, 15, k + 1, 0, 0);
        push(EvShift, 15, k + 19, 18, 0);
        wait_cyc(k + 3);
        door_hold = 1'b1;
        wait_cyc(k + 13);
        door_hold = 1'b0;
        wait_cyc(k + 20);
        head_floor = 4'd0;
        wait_cyc(cyc + 5);
`endif

        check("final_floor", int'(current_floor), model_floor);
        check("pending_events", exp_q.size(), 0);
        check("dir_exclusive", excl_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
